// File: rtl/float_calc_seq_if.sv
// float_calc_seq_if: request/response bundle between the operand registers and the float calculator.
// Parameters must match the float_calc_seq instance that uses the slave modport.
interface float_calc_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  // Handshake: start is taken only while busy is low (this includes the cycle in
  // which done pulses); op/A/B are captured on that edge and may change afterwards.
  // busy stays high until the result is ready, then done pulses for exactly one
  // cycle and result/ovf/unf/err hold their values until the next done.
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;
  logic         unf;
  logic         err;

  modport master (
    output start, op, A, B,
    input  busy, done, result, ovf, unf, err
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result, ovf, unf, err
  );
endinterface

// File: rtl/float_calc_seq.sv
// float_calc_seq: sequential add/sub/mul/div on EXP_W/MAN_W floats with an iterative divider.
// Optional macro FLOAT_CALC_RNE_EN: round to nearest-even in NORM instead of truncating.
module float_calc_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst,
  float_calc_seq_if.slave bus,
  output logic [1:0]      state_dbg
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int N  = 2 * MAN_W + 2;   // working mantissa: binary point sits below bit 2*MAN_W
  localparam int EW = EXP_W + 8;       // signed working exponent with headroom
  localparam int CW = $clog2(MAN_W + 3);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] FRAC_POS = EW'(2 * MAN_W);
  localparam logic [CW-1:0]        DIV_LAST = CW'(MAN_W + 2);
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_EXEC, S_NORM} state_t;

  function automatic logic signed [EW-1:0] ext(input logic [EXP_W-1:0] e);
    return $signed({{(EW-EXP_W){1'b0}}, e});
  endfunction

  state_t state_q, state_d;

  // captured request
  logic [W-1:0] a_q, b_q;
  logic [1:0]   op_q;

  // unpacked operands
  logic             sa_q, sb_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [MAN_W:0]   ma_q, mb_q;
  logic             za_q, zb_q, ia_q, ib_q, na_q, nb_q;

  // EXEC results and divider state
  logic [N-1:0]         rm_q;
  logic signed [EW-1:0] rexp_q;
  logic                 rsign_q;
  logic [MAN_W+1:0]     rem_q;
  logic [MAN_W+2:0]     quo_q;
  logic [CW-1:0]        cnt_q;

  // output registers
  logic [W-1:0] result_q;
  logic         done_q, ovf_q, unf_q, err_q;

  // ---------------- unpack classification ----------------
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MAN_W-1:0] ua_frac, ub_frac;
  logic             ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan;
  logic [MAN_W:0]   ua_man, ub_man;

  assign ua_exp  = a_q[W-2 -: EXP_W];
  assign ub_exp  = b_q[W-2 -: EXP_W];
  assign ua_frac = a_q[MAN_W-1:0];
  assign ub_frac = b_q[MAN_W-1:0];
  assign ua_zero = (ua_exp == '0);
  assign ub_zero = (ub_exp == '0);
  assign ua_inf  = (ua_exp == EXP_ONES) && (ua_frac == '0);
  assign ub_inf  = (ub_exp == EXP_ONES) && (ub_frac == '0);
  assign ua_nan  = (ua_exp == EXP_ONES) && (ua_frac != '0);
  assign ub_nan  = (ub_exp == EXP_ONES) && (ub_frac != '0);
  // denormals flush to zero, so a zero exponent also clears the hidden bit
  assign ua_man  = ua_zero ? '0 : {1'b1, ua_frac};
  assign ub_man  = ub_zero ? '0 : {1'b1, ub_frac};

  // ---------------- EXEC datapath ----------------
  logic                 sb_eff, a_big, align_sticky, exec_sign;
  logic [EXP_W-1:0]     big_e, small_e;
  logic [N-1:0]         big_x, small_x, small_sh, add_m, mul_m, exec_m;
  int                   ediff;
  logic signed [EW-1:0] exec_exp;
  logic                 div_ge;
  logic [MAN_W+1:0]     div_rem;

  always_comb begin
    sb_eff   = sb_q ^ (op_q == OP_SUB);
    a_big    = {ea_q, ma_q} >= {eb_q, mb_q};
    big_e    = a_big ? ea_q : eb_q;
    small_e  = a_big ? eb_q : ea_q;
    big_x    = a_big ? {1'b0, ma_q, {MAN_W{1'b0}}} : {1'b0, mb_q, {MAN_W{1'b0}}};
    small_x  = a_big ? {1'b0, mb_q, {MAN_W{1'b0}}} : {1'b0, ma_q, {MAN_W{1'b0}}};
    ediff    = int'(big_e) - int'(small_e);

    // bits shifted out of the smaller operand fold into a sticky LSB
    small_sh     = '0;
    align_sticky = |small_x;
    if (ediff < N) begin
      small_sh     = small_x >> ediff;
      align_sticky = |(small_x & ~({N{1'b1}} << ediff));
    end
    small_sh[0] = small_sh[0] | align_sticky;

    add_m  = (sa_q == sb_eff) ? (big_x + small_sh) : (big_x - small_sh);
    mul_m  = N'(ma_q) * N'(mb_q);
    exec_m = (op_q == OP_MUL) ? mul_m : add_m;

    exec_exp  = ext(big_e);
    exec_sign = a_big ? sa_q : sb_eff;
    case (op_q)
      OP_MUL: begin
        exec_exp  = ext(ea_q) + ext(eb_q) - BIAS;
        exec_sign = sa_q ^ sb_q;
      end
      OP_DIV: begin
        exec_exp  = ext(ea_q) - ext(eb_q) + BIAS;
        exec_sign = sa_q ^ sb_q;
      end
      default: ;
    endcase

    // one restoring-division step per EXEC cycle
    div_ge  = rem_q >= {1'b0, mb_q};
    div_rem = div_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
  end

  // ---------------- NORM: normalise, round, repack ----------------
  logic [N-1:0]         div_m, nm, nsh;
  int                   lead;
  logic [MAN_W-1:0]     mant;
  logic signed [EW-1:0] exp_n;
`ifdef FLOAT_CALC_RNE_EN
  logic                 rnd_up;
  logic [MAN_W:0]       mant_r;
`endif

  always_comb begin
    // quotient MSB weighs 2^0; a non-zero remainder becomes the sticky bit
    div_m = (N'(quo_q) << (MAN_W - 2)) | N'(rem_q != '0);
    nm    = (op_q == OP_DIV) ? div_m : rm_q;
    lead  = 0;
    for (int i = 0; i < N; i++) begin
      if (nm[i]) lead = i;
    end
    nsh   = nm << (N - 1 - lead);
    mant  = nsh[N-2 -: MAN_W];
    exp_n = rexp_q + EW'(lead) - FRAC_POS;
`ifdef FLOAT_CALC_RNE_EN
    rnd_up = nsh[MAN_W] & (nsh[MAN_W-1] | (|nsh[MAN_W-2:0]) | mant[0]);
    mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, rnd_up};
    mant   = mant_r[MAN_W-1:0];
    if (mant_r[MAN_W]) exp_n = exp_n + EW'(1);
`endif
  end

`ifndef FLOAT_CALC_RNE_EN
  logic unused_low_bits;
  assign unused_low_bits = ^nsh[MAN_W:0];
`endif

  // special operands bypass the arithmetic result
  logic         spec_hit, spec_err, sx;
  logic [W-1:0] spec_res;

  always_comb begin
    spec_hit = 1'b0;
    spec_err = 1'b0;
    spec_res = '0;
    sx       = sa_q ^ sb_q;
    if (na_q || nb_q) begin
      spec_hit = 1'b1; spec_err = 1'b1; spec_res = QNAN;
    end else begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          if (ia_q && ib_q) begin
            spec_hit = 1'b1;
            if (sa_q == sb_eff) spec_res = {sa_q, EXP_ONES, {MAN_W{1'b0}}};
            else begin spec_res = QNAN; spec_err = 1'b1; end
          end else if (ia_q) begin
            spec_hit = 1'b1; spec_res = {sa_q, EXP_ONES, {MAN_W{1'b0}}};
          end else if (ib_q) begin
            spec_hit = 1'b1; spec_res = {sb_eff, EXP_ONES, {MAN_W{1'b0}}};
          end
        end
        OP_MUL: begin
          if ((za_q && ib_q) || (ia_q && zb_q)) begin
            spec_hit = 1'b1; spec_err = 1'b1; spec_res = QNAN;
          end else if (ia_q || ib_q) begin
            spec_hit = 1'b1; spec_res = {sx, EXP_ONES, {MAN_W{1'b0}}};
          end else if (za_q || zb_q) begin
            spec_hit = 1'b1; spec_res = {sx, {(W-1){1'b0}}};
          end
        end
        default: begin
          if ((ia_q && ib_q) || (za_q && zb_q)) begin
            spec_hit = 1'b1; spec_err = 1'b1; spec_res = QNAN;
          end else if (ia_q) begin
            spec_hit = 1'b1; spec_res = {sx, EXP_ONES, {MAN_W{1'b0}}};
          end else if (ib_q) begin
            spec_hit = 1'b1; spec_res = {sx, {(W-1){1'b0}}};
          end else if (zb_q) begin
            spec_hit = 1'b1; spec_err = 1'b1; spec_res = {sx, EXP_ONES, {MAN_W{1'b0}}};
          end else if (za_q) begin
            spec_hit = 1'b1; spec_res = {sx, {(W-1){1'b0}}};
          end
        end
      endcase
    end
  end

  logic [W-1:0] res_d;
  logic         ovf_d, unf_d, err_d;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    err_d = 1'b0;
    if (spec_hit) begin
      res_d = spec_res;
      err_d = spec_err;
    end else if (nm == '0) begin
      res_d = '0;
    end else if (exp_n >= EMAX) begin
      res_d = {rsign_q, EXP_ONES, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (exp_n[EW-1] || (exp_n == '0)) begin
      res_d = {rsign_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end else begin
      res_d = {rsign_q, exp_n[EXP_W-1:0], mant};
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_UNPACK;
      S_UNPACK: state_d = S_EXEC;
      S_EXEC:   if (op_q != OP_DIV || cnt_q == DIV_LAST) state_d = S_NORM;
      S_NORM:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_NORM);
      if (state_q == S_NORM) begin
        result_q <= res_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        err_q    <= err_d;
      end
    end
  end

  // datapath registers carry no reset: they are always loaded before use
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_q  <= bus.A;
          b_q  <= bus.B;
          op_q <= bus.op;
        end
      end
      S_UNPACK: begin
        sa_q  <= a_q[W-1];
        sb_q  <= b_q[W-1];
        ea_q  <= ua_exp;
        eb_q  <= ub_exp;
        ma_q  <= ua_man;
        mb_q  <= ub_man;
        za_q  <= ua_zero;
        zb_q  <= ub_zero;
        ia_q  <= ua_inf;
        ib_q  <= ub_inf;
        na_q  <= ua_nan;
        nb_q  <= ub_nan;
        rem_q <= {1'b0, ua_man};
        quo_q <= '0;
        cnt_q <= '0;
      end
      S_EXEC: begin
        rexp_q  <= exec_exp;
        rsign_q <= exec_sign;
        if (op_q == OP_DIV) begin
          rem_q <= {div_rem[MAN_W:0], 1'b0};
          quo_q <= {quo_q[MAN_W+1:0], div_ge};
          cnt_q <= cnt_q + CW'(1);
        end else begin
          rm_q <= exec_m;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.unf    = unf_q;
  assign bus.err    = err_q;
  assign state_dbg  = state_q;

endmodule
